// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, iteration count.
// Latency: none (package only).
// Backpressure: none (package only).
package muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110,
        OP_RSVD  = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIX  = 2'b11
    } md_state_e;

    // One iteration per operand bit.
    localparam int ITER_COUNT = 32;
    localparam logic [4:0] LAST_ITER = 5'(ITER_COUNT - 1);

    // Magnitude of a possibly signed operand; unsigned ops pass through untouched.
    function automatic logic [31:0] mag(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module muldiv_step
    import muldiv_ctrl_pkg::*;
(
    input  logic        is_div,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic [31:0] opd,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    logic [32:0] x;
    logic [32:0] y;
    logic [32:0] sum;
    logic        neg;

    // Single 33-bit adder: add multiplicand (mul) or subtract divisor (div), then shift.
    always_comb begin
        x      = is_div ? {hi_in, lo_in[31]} : {1'b0, hi_in};
        y      = is_div ? ~{1'b0, opd} : (lo_in[0] ? {1'b0, opd} : 33'd0);
        sum    = x + y + {32'd0, is_div};
        neg    = 1'b0;
        hi_out = sum[32:1];
        lo_out = {sum[0], lo_in[31:1]};
        if (is_div) begin
            // Partial remainder is always below the divisor, so bit 32 is the borrow.
            neg    = sum[32];
            hi_out = neg ? x[31:0] : sum[31:0];
            lo_out = {lo_in[30:0], ~neg};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MIPS-style multiply/divide unit owning the architectural HI/LO registers.
// Latency: mul/div busy for 33 cycles after accept; results and done in the first idle cycle.
// Backpressure: start is dropped (not queued) while busy; abort cancels without writeback.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        abort,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        dz,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e   state, state_nxt;
    md_op_e      op_e;
    logic [4:0]  cnt;
    logic [31:0] w_hi, w_lo, w_opd, a_lat;
    logic        is_div_r, neg_res, neg_rem, dz_case;
    logic        accept, is_mul_op, is_div_op, is_signed, sa, sb;
    logic [31:0] step_hi, step_lo;
    logic [63:0] prod, prod_fix;
    logic [31:0] fix_hi, fix_lo;

    assign op_e      = md_op_e'(op);
    assign is_mul_op = (op_e == OP_MULT) || (op_e == OP_MULTU);
    assign is_div_op = (op_e == OP_DIV)  || (op_e == OP_DIVU);
    assign is_signed = (op_e == OP_MULT) || (op_e == OP_DIV);
    assign sa        = is_signed && a[31];
    assign sb        = is_signed && b[31];
    assign accept    = (state == ST_IDLE) && start && !abort;

    muldiv_step u_step (
        .is_div (is_div_r),
        .hi_in  (w_hi),
        .lo_in  (w_lo),
        .opd    (w_opd),
        .hi_out (step_hi),
        .lo_out (step_lo)
    );

    // State register; reset throws away any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: 32 iterations then one sign-fixup cycle; abort always returns to idle.
    always_comb begin
        state_nxt = state;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (accept && is_mul_op)      state_nxt = ST_MUL;
                else if (accept && is_div_op) state_nxt = ST_DIV;
            end
            ST_MUL, ST_DIV: begin
                if (abort)                 state_nxt = ST_IDLE;
                else if (cnt == LAST_ITER) state_nxt = ST_FIX;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Sign fixup of the magnitude result, plus the divide-by-zero override.
    always_comb begin
        prod     = {w_hi, w_lo};
        prod_fix = neg_res ? (~prod + 64'd1) : prod;
        fix_hi   = prod_fix[63:32];
        fix_lo   = prod_fix[31:0];
        if (is_div_r) begin
            if (dz_case) begin
                fix_hi = a_lat;
                fix_lo = 32'hFFFF_FFFF;
            end else begin
                fix_hi = neg_rem ? (~w_hi + 32'd1) : w_hi;
                fix_lo = neg_res ? (~w_lo + 32'd1) : w_lo;
            end
        end
    end

    // Datapath: operand latch on accept, one step per iteration, HI/LO writeback at FIX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 5'd0;
            w_hi     <= 32'd0;
            w_lo     <= 32'd0;
            w_opd    <= 32'd0;
            a_lat    <= 32'd0;
            is_div_r <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dz_case  <= 1'b0;
            done     <= 1'b0;
            dz       <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (op_e == OP_MTHI) hi <= a;
                        if (op_e == OP_MTLO) lo <= a;
                        if (is_mul_op || is_div_op) begin
                            cnt      <= 5'd0;
                            w_hi     <= 32'd0;
                            a_lat    <= a;
                            is_div_r <= is_div_op;
                            neg_res  <= sa ^ sb;
                            neg_rem  <= sa;
                            dz_case  <= is_div_op && (b == 32'd0);
                            // Multiplier shifts out of LO; dividend shifts out of LO.
                            w_lo     <= is_div_op ? mag(a, is_signed) : mag(b, is_signed);
                            w_opd    <= is_div_op ? mag(b, is_signed) : mag(a, is_signed);
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (!abort) begin
                        w_hi <= step_hi;
                        w_lo <= step_lo;
                        cnt  <= cnt + 5'd1;
                    end
                end
                default: begin
                    if (!abort) begin
                        hi   <= fix_hi;
                        lo   <= fix_lo;
                        done <= 1'b1;
                        if (is_div_r) dz <= dz_case;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: arithmetic reference model plus directed vectors.
// Latency: model expects 33 busy cycles and done in the first idle cycle.
// Backpressure: exercises ignored starts while busy, abort and mid-operation reset.
module tb_muldiv_ctrl;

    localparam logic [2:0] C_MULT = 3'd1, C_MULTU = 3'd2, C_DIV = 3'd3, C_DIVU = 3'd4;
    localparam logic [2:0] C_MTHI = 3'd5, C_MTLO = 3'd6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start, abort;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    muldiv_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .abort (abort),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    int          m_left = 0;
    bit          m_done = 1'b0;
    bit          m_dz   = 1'b0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;
    logic [31:0] p_hi, p_lo;
    bit          p_dzw, p_dzv;

    function automatic void compute(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                                    output logic [31:0] rh, output logic [31:0] rl,
                                    output bit dzw, output bit dzv);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa  = $signed(va);
        sb  = $signed(vb);
        dzw = 1'b0;
        dzv = 1'b0;
        rh  = 32'd0;
        rl  = 32'd0;
        if (o == C_MULT) begin
            p = sa * sb;
            {rh, rl} = p;
        end else if (o == C_MULTU) begin
            p = {32'd0, va} * {32'd0, vb};
            {rh, rl} = p;
        end else begin
            dzw = 1'b1;
            if (vb == 32'd0) begin
                rh  = va;
                rl  = 32'hFFFF_FFFF;
                dzv = 1'b1;
            end else if (o == C_DIV) begin
                q  = sa / sb;
                r  = sa % sb;
                rl = q[31:0];
                rh = r[31:0];
            end else begin
                rl = va / vb;
                rh = va % vb;
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0; m_done = 1'b0; m_dz = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                if (abort) m_left = 0;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                        if (p_dzw) m_dz = p_dzv;
                    end
                end
            end else if (start && !abort) begin
                if (op >= C_MULT && op <= C_DIVU) begin
                    compute(op, a, b, p_hi, p_lo, p_dzw, p_dzv);
                    m_left = 33;
                end else if (op == C_MTHI) m_hi = a;
                else if (op == C_MTLO)     m_lo = a;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cyc_busy", 64'(busy), 64'(m_left > 0));
        chk("cyc_done", 64'(done), 64'(m_done));
        chk("cyc_dz",   64'(dz),   64'(m_dz));
        chk("cyc_hi",   64'(hi),   64'(m_hi));
        chk("cyc_lo",   64'(lo),   64'(m_lo));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
        start = 1'b1; op = o; a = va; b = vb;
    endtask

    task automatic idle_in();
        start = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
    endtask

    // Waits (bounded) for done, counting busy cycles on the way.
    task automatic wait_done(input string nm);
        int nb;
        bit seen;
        nb = 0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) nb++;
        end
        chk({nm, "_done_seen"}, 64'(seen), 64'd1);
        chk({nm, "_busy_cycles"}, 64'(nb), 64'd33);
    endtask

    task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
        tick();
        drive(o, va, vb);
        tick();
        idle_in();
        wait_done(nm);
    endtask

    task automatic count_done(input string nm, input int ncyc);
        int nd;
        nd = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk({nm, "_no_done"}, 64'(nd), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        start = 1'b0; abort = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dz",   64'(dz),   64'd0);
        chk("rst_hi",   64'(hi),   64'd0);
        chk("rst_lo",   64'(lo),   64'd0);
        tick();
        rst = 1'b0;

        run_op("multu_max", C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("multu_max_lo", 64'(lo), 64'h0000_0001);

        run_op("mult_neg", C_MULT, 32'hFFFF_FFFD, 32'd7);
        chk("mult_neg_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_neg_lo", 64'(lo), 64'hFFFF_FFEB);

        run_op("div_neg", C_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("div_neg_dz", 64'(dz), 64'd0);

        run_op("divu_zero", C_DIVU, 32'd7, 32'd0);
        chk("divu_zero_hi", 64'(hi), 64'd7);
        chk("divu_zero_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("divu_zero_dz", 64'(dz), 64'd1);

        run_op("mult_keepdz", C_MULT, 32'd2, 32'd3);
        chk("mult_keepdz_lo", 64'(lo), 64'd6);
        chk("mult_keepdz_dz", 64'(dz), 64'd1);

        run_op("div_ovf", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
        chk("div_ovf_hi", 64'(hi), 64'd0);
        chk("div_ovf_dz", 64'(dz), 64'd0);

        // Back-to-back: start presented during the done cycle.
        drive(C_DIVU, 32'd100, 32'd7);
        tick();
        idle_in();
        wait_done("b2b_divu");
        chk("b2b_divu_lo", 64'(lo), 64'd14);
        chk("b2b_divu_hi", 64'(hi), 64'd2);

        // mthi then mtlo on consecutive cycles.
        tick();
        drive(C_MTHI, 32'h1234_5678, 32'd0);
        tick();
        drive(C_MTLO, 32'h9ABC_DEF0, 32'd0);
        tick();
        idle_in();
        @(negedge clk);
        chk("mthi_hi", 64'(hi), 64'h1234_5678);
        chk("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
        chk("mtx_busy", 64'(busy), 64'd0);
        count_done("mtx", 4);

        // Abort on busy cycle 10, with an ignored mthi on busy cycle 5.
        tick();
        drive(C_MULTU, 32'd3, 32'd5);
        tick();
        idle_in();
        for (int i = 0; i < 4; i++) tick();
        drive(C_MTHI, 32'hDEAD_BEEF, 32'd0);
        tick();
        idle_in();
        for (int i = 0; i < 4; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'h1234_5678);
        chk("abort_lo", 64'(lo), 64'h9ABC_DEF0);
        count_done("abort", 40);

        // Abort together with start in idle suppresses the start.
        tick();
        drive(C_MULT, 32'd9, 32'd9);
        abort = 1'b1;
        tick();
        idle_in();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_start_busy", 64'(busy), 64'd0);

        // Abort at the FIX edge: no writeback.
        tick();
        drive(C_MULT, 32'd4, 32'd4);
        tick();
        idle_in();
        for (int i = 0; i < 32; i++) tick();
        chk("fix_busy_before", 64'(busy), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        count_done("abort_fix", 5);
        chk("abort_fix_lo", 64'(lo), 64'h9ABC_DEF0);

        // Reset on busy cycle 20 of a divide.
        tick();
        drive(C_DIV, 32'd100, 32'd3);
        tick();
        idle_in();
        for (int i = 0; i < 19; i++) tick();
        rst = 1'b1;
        #1;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        chk("mrst_dz",   64'(dz),   64'd0);
        chk("mrst_hi",   64'(hi),   64'd0);
        chk("mrst_lo",   64'(lo),   64'd0);
        tick();
        rst = 1'b0;
        run_op("mult_67", C_MULT, 32'd6, 32'd7);
        chk("mult_67_lo", 64'(lo), 64'd42);
        chk("mult_67_hi", 64'(hi), 64'd0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL use reset rst, asynchronous, active-high, and clock clk.
REQ-002 Port clk, input, 1 bit: rising-edge clock.
REQ-003 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 Port start, input, 1 bit: request for a multiply, divide or HI/LO move.
REQ-005 Port op, input, 3 bits: operation code. 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none).
REQ-006 Port abort, input, 1 bit: cancel the operation in flight (interrupt entry).
REQ-007 Port a, input, 32 bits: rs operand (dividend or multiplicand).
REQ-008 Port b, input, 32 bits: rt operand (divisor or multiplier).
REQ-009 Port busy, output, 1 bit: high while an iterative operation is in progress.
REQ-010 Port done, output, 1 bit: one-cycle completion pulse.
REQ-011 Port dz, output, 1 bit: sticky divide-by-zero flag for the last divide.
REQ-012 Ports hi and lo, outputs, 32 bits each: architectural HI and LO registers.

Function
REQ-013 Accept rule: start is accepted on a rising edge where start=1, busy=0, abort=0 and op is valid. When start is low or op is none or reserved, the request is ignored.
REQ-014 Start while busy=1 SHALL be ignored; requests are not queued.
REQ-015 mthi and mtlo SHALL write a into hi or lo at the accepting edge. They do not assert busy or done.
REQ-016 States SHALL be IDLE, MUL, DIV and FIX.
- IDLE to MUL on an accepted mult or multu.
- IDLE to DIV on an accepted div or divu.
- MUL or DIV to FIX after 32 iterations, counted with a 5-bit counter running 0 to 31.
- FIX to IDLE unconditionally.
REQ-017 Latency:
- busy SHALL go high in the cycle after the accepting edge and stay high for exactly 33 cycles (32 iterations plus FIX).
- hi, lo and done SHALL update in the first cycle busy is low, with done high for exactly one cycle.
REQ-018 Operands SHALL be latched at the accepting edge; later changes to a and b have no effect.
REQ-019 The multiply SHALL iterate shift-add on operand magnitudes, one bit per cycle. For signed mult with sign(a)^sign(b)=1, FIX negates the 64-bit product. Result goes to {hi,lo}.
REQ-020 The divide SHALL iterate restoring division on magnitudes, one quotient bit per cycle.
- lo = quotient, hi = remainder.
- For signed div, quotient is negated if sign(a)^sign(b)=1 and remainder takes the sign of a.
REQ-021 Divide by zero (b=0, div or divu) SHALL take the same 33 cycles. Result is hi=a, lo=0xFFFFFFFF regardless of sign, and dz is set to 1.
REQ-022 Any divide with b≠0 SHALL clear dz at completion. Multiplies leave dz unchanged.
REQ-023 Signed overflow case div 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0 with no exception.
REQ-024 hi and lo SHALL hold their previous values throughout busy.
REQ-025 Abort:
- abort=1 while busy=1 SHALL return to IDLE at the next edge, with hi, lo and dz unchanged and no done pulse.
- abort in the same cycle as start in IDLE suppresses the start.
- abort at the FIX edge wins, so no writeback occurs.
REQ-026 Back-to-back operations: a new start is acceptable at the same edge that produces done, i.e. the first busy-low cycle.

Reset
REQ-027 On rst: state=IDLE, counter=0, busy=0, done=0, dz=0, hi=0, lo=0, operand and partial-result registers=0.
REQ-028 Reset mid-operation SHALL discard the operation immediately with no done pulse; it takes effect asynchronously.

Structure
REQ-029 Op codes, state encodings and the iteration count constant (32) SHALL live in the shared header, alongside the existing ALU and PC op macros.
REQ-030 One sub-module, muldiv_step, SHALL implement a single combinational iteration: a 33-bit add/sub plus shift, selected by mul/div. The FSM, counter and HI/LO registers stay in muldiv_ctrl.

Verification
REQ-031 multu a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 busy cycles, hi=0xFFFFFFFE, lo=0x00000001, done pulses for 1 cycle.
REQ-032 mult a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-033 div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. A following divu a=7, b=0 -> hi=7, lo=0xFFFFFFFF, dz=1.
REQ-034 mthi a=0x12345678 then mtlo a=0x9ABCDEF0 on consecutive cycles -> hi and lo written, busy stays 0, no done.
REQ-035 Start multu 3×5, assert abort on busy cycle 10 -> IDLE next cycle, hi and lo keep prior values, no done. A start issued while busy is ignored.
REQ-036 Assert rst on busy cycle 20 of a div -> all outputs 0 immediately. After release, a new mult 6×7 gives lo=42, hi=0.
